alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 16-bit combinational ALU.
- Keeps the existing 8 opcodes, adds shifts and an iterative multiply, and produces status flags.
- Uses valid/ready handshakes on both sides so it can sit between the register file and the writeback stage of the data path.
- Single-cycle ops give 1-cycle latency. MUL is multi-cycle and stalls the input.

---
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and an iterative shift-add multiply.
// Optional feature: define ALU_SAT_EN for signed saturation on ADD, SUB and INC.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [4:0]       flags
);

    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] q_q;
    logic [4:0]       flags_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] res_d;
    logic [4:0]       flg_d;
    logic [WIDTH-1:0] acc_d;
    logic             c_d, v_d, err_d;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   sum_ext, dif_ext, inc_ext, shl_ext, shr_ext, sra_ext;

    assign in_ready  = !reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign flags     = flags_q;

    assign amt = B[SHW-1:0];
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Shifts run on a WIDTH+1 vector so the extra bit captures the last bit shifted out.
    always_comb begin
        sum_ext = {1'b0, A} + {1'b0, B};
        dif_ext = {1'b0, A} - {1'b0, B};
        inc_ext = {1'b0, A} + (WIDTH + 1)'(1);
        shl_ext = {1'b0, A} << amt;
        shr_ext = {A, 1'b0} >> amt;
        sra_ext = $signed({A, 1'b0}) >>> amt;
        res_d   = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        err_d   = 1'b0;
        case (Sel)
            4'd0:  res_d = '0;
            4'd1: begin
                res_d = sum_ext[M:0];
                c_d   = sum_ext[WIDTH];
                v_d   = (A[M] == B[M]) && (sum_ext[M] != A[M]);
            end
            4'd2: begin
                res_d = dif_ext[M:0];
                c_d   = dif_ext[WIDTH];
                v_d   = (A[M] != B[M]) && (dif_ext[M] != A[M]);
            end
            4'd3:  res_d = A;
            4'd4:  res_d = A ^ B;
            4'd5:  res_d = A | B;
            4'd6:  res_d = A & B;
            4'd7: begin
                res_d = inc_ext[M:0];
                c_d   = inc_ext[WIDTH];
                v_d   = !A[M] && inc_ext[M];
            end
            4'd8: begin
                res_d = shl_ext[M:0];
                c_d   = shl_ext[WIDTH];
            end
            4'd9: begin
                res_d = shr_ext[WIDTH:1];
                c_d   = shr_ext[0];
            end
            4'd10: begin
                res_d = sra_ext[WIDTH:1];
                c_d   = sra_ext[0];
            end
            4'd11: res_d = '0;
            default: err_d = 1'b1;
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction always follows the sign of A for add, sub and increment.
        if (v_d) begin
            res_d = A[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
        end
`else
`endif
        flg_d = {err_d, v_d, c_d, res_d[M], res_d == '0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (Sel == 4'd11) begin
                            state_q  <= MUL;
                            mcand_q  <= A;
                            mplier_q <= B;
                            acc_q    <= '0;
                            cnt_q    <= CW'(WIDTH);
                        end else begin
                            q_q         <= res_d;
                            flags_q     <= flg_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        q_q         <= acc_d;
                        flags_q     <= {3'b000, acc_d[M], acc_d == '0};
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors checked with immediate assertions.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A, B, Q;
    logic [3:0]  Sel;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q [1:7];
    logic [4:0]  exp_f [1:7];

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] q, input logic [4:0] f);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_q"}, 32'(Q), 32'(q));
        chk({tag, "_flags"}, 32'(flags), 32'(f));
    endtask

    task automatic issue(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        Sel = s; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Sel = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        issue(4'd1, 16'h0003, 16'h0004);
        chk_res("add_3_4", 16'h0007, 5'b00000);

        issue(4'd1, 16'h7FFF, 16'h0001);
`ifdef ALU_SAT_EN
        chk_res("add_ovf", 16'h7FFF, 5'b01000);
`else
        chk_res("add_ovf", 16'h8000, 5'b01010);
`endif
        issue(4'd2, 16'h0000, 16'h0001);
        chk_res("sub_borrow", 16'hFFFF, 5'b00110);
        issue(4'd7, 16'hFFFF, 16'h0000);
        chk_res("inc_wrap", 16'h0000, 5'b00101);

        issue(4'd10, 16'h8010, 16'h0004);
        chk_res("sra4", 16'hF801, 5'b00010);
        issue(4'd8, 16'h8001, 16'h0001);
        chk_res("shl1", 16'h0002, 5'b00100);
        issue(4'd9, 16'h8001, 16'h0000);
        chk_res("shr0", 16'h8001, 5'b00010);
        issue(4'd12, 16'h1234, 16'h5678);
        chk_res("illegal", 16'h0000, 5'b10001);

        // multiply: 16 busy cycles, result in cycle 17 after accept
        issue(4'd11, 16'd300, 16'd300);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("mul_busy_rdy%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("mul_busy_vld%0d", i), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk_res("mul_300", 16'h5F90, 5'b00000);
        chk("mul_done_rdy", 32'(in_ready), 32'd1);

        // reset in the 8th multiply cycle aborts the operation
        issue(4'd11, 16'd300, 16'd300);
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("mulrst_rdy_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mulrst_valid", 32'(out_valid), 32'd0);
        chk("mulrst_ready", 32'(in_ready), 32'd1);
        chk("mulrst_q", 32'(Q), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mulrst_novalid%0d", i), 32'(out_valid), 32'd0);
        end

        // back-pressure on a stream of AND ops
        Sel = 4'd6; A = 16'hF0F0; B = 16'hFF00; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        A = 16'h1234; B = 16'h00FF;
        #1;
        chk("bp_rdy0", 32'(in_ready), 32'd0);
        chk_res("bp_first", 16'hF000, 5'b00010);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_rdy%0d", i), 32'(in_ready), 32'd0);
            chk_res($sformatf("bp_hold%0d", i), 16'hF000, 5'b00010);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk_res("bp_second", 16'h0034, 5'b00000);
        A = 16'hAAAA; B = 16'h5555;
        @(posedge clk); #1;
        chk_res("bp_third", 16'h0000, 5'b00001);
        A = 16'hFFFF; B = 16'h8001;
        @(posedge clk); #1;
        chk_res("bp_fourth", 16'h8001, 5'b00010);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drained", 32'(out_valid), 32'd0);

        // ops 1..7 back-to-back on A=C000, B=4001
        exp_q[1] = 16'h0001; exp_f[1] = 5'b00100;
`ifdef ALU_SAT_EN
        exp_q[2] = 16'h8000; exp_f[2] = 5'b01010;
`else
        exp_q[2] = 16'h7FFF; exp_f[2] = 5'b01000;
`endif
        exp_q[3] = 16'hC000; exp_f[3] = 5'b00010;
        exp_q[4] = 16'h8001; exp_f[4] = 5'b00010;
        exp_q[5] = 16'hC001; exp_f[5] = 5'b00010;
        exp_q[6] = 16'h4000; exp_f[6] = 5'b00000;
        exp_q[7] = 16'hC001; exp_f[7] = 5'b00010;
        A = 16'hC000; B = 16'h4001; Sel = 4'd1; in_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            chk_res($sformatf("b2b_op%0d", k), exp_q[k], exp_f[k]);
            if (k == 7) in_valid = 1'b0;
            else        Sel = 4'(k + 1);
        end
        @(posedge clk); #1;
        chk("b2b_drained", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
